// File: rtl/execute_pipe_pkg.sv
// Shared constants for the execute stage: ALU/MD/MF encodings, bubble word, MD iteration count.
package execute_pipe_pkg;

    localparam logic [31:0] NOP_IR  = 32'h0000_0000;
    localparam int unsigned MD_ITER = 32;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluNor  = 4'd5;
    localparam logic [3:0] AluSlt  = 4'd6;
    localparam logic [3:0] AluSltu = 4'd7;
    localparam logic [3:0] AluSll  = 4'd8;
    localparam logic [3:0] AluSrl  = 4'd9;
    localparam logic [3:0] AluSra  = 4'd10;
    localparam logic [3:0] AluLui  = 4'd11;

    localparam logic [1:0] MdMult  = 2'b00;
    localparam logic [1:0] MdMultu = 2'b01;
    localparam logic [1:0] MdDiv   = 2'b10;
    localparam logic [1:0] MdDivu  = 2'b11;

    localparam logic [1:0] MfAlu = 2'b00;
    localparam logic [1:0] MfHi  = 2'b01;
    localparam logic [1:0] MfLo  = 2'b10;

    typedef enum logic [1:0] {MdIdle, MdRun, MdDone} md_state_e;

    function automatic logic [31:0] neg_if(input logic c, input logic [31:0] x);
        return c ? -x : x;
    endfunction

endpackage

// File: rtl/execute_pipe_muldiv_iter.sv
// Iterative 32-step multiply/divide unit with HI/LO. Signed ops run on magnitudes and
// fix signs when the result is written.
module muldiv_iter
    import execute_pipe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        hold_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CntW = $clog2(MD_ITER);
    localparam logic [CntW-1:0] LastIter = CntW'(MD_ITER - 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [63:0]     acc_q, acc_step, prod;
    logic [31:0]     opnd_q, hi_q, lo_q, hi_res, lo_res;
    logic            is_div_q, neg_q, neg_rem_q, dz_q;
    logic            load, step, write;
    logic            op_div, op_signed, sa, sb;
    logic [32:0]     sum, rem_top, diff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MdIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MdIdle:  if (start_i && !hold_i) state_d = MdRun;
            MdRun:   if (cnt_q == LastIter) state_d = MdDone;
            MdDone:  if (!hold_i) state_d = MdIdle;
            default: state_d = MdIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q != MdIdle);
        load   = (state_q == MdIdle) && start_i && !hold_i;
        step   = (state_q == MdRun);
        write  = (state_q == MdDone) && !hold_i;
    end

    assign op_div    = (op_i == MdDiv) || (op_i == MdDivu);
    assign op_signed = (op_i == MdMult) || (op_i == MdDiv);
    assign sa        = op_signed & a_i[31];
    assign sb        = op_signed & b_i[31];

    // acc holds {partial, multiplier} for mult and {remainder, quotient} for div.
    always_comb begin
        sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'h0);
        rem_top = acc_q[63:31];
        diff    = rem_top - {1'b0, opnd_q};
        if (is_div_q) begin
            acc_step = diff[32] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            acc_step = {sum, acc_q[31:1]};
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        if (is_div_q) begin
            lo_res = dz_q ? 32'hFFFF_FFFF : neg_if(neg_q, acc_q[31:0]);
            hi_res = neg_if(neg_rem_q, acc_q[63:32]);
        end else begin
            lo_res = prod[31:0];
            hi_res = prod[63:32];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (load) begin
                cnt_q     <= '0;
                acc_q     <= {32'h0, neg_if(sa, a_i)};
                opnd_q    <= neg_if(sb, b_i);
                is_div_q  <= op_div;
                neg_q     <= sa ^ sb;
                neg_rem_q <= sa;
                dz_q      <= (b_i == 32'h0);
            end
            if (step) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= acc_step;
            end
            if (write) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/execute_pipe.sv
// MIPS execute stage: ALU, XM pipeline registers and, with MULDIV_EN defined, the
// iterative multiply/divide unit with HI/LO and its MFHI/MFLO/start interlock.
module execute_pipe
    import execute_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic [31:0] DX_IR,
    input  logic [31:0] DX_A,
    input  logic [31:0] DX_B,
    input  logic [31:0] DX_IMM,
    input  logic [3:0]  alu_op,
    input  logic        use_imm,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [1:0]  mf_sel,
    input  logic        wb_we_in,
    input  logic [4:0]  wb_reg_addr_in,
    output logic [31:0] XM_IR,
    output logic [31:0] XM_O,
    output logic [31:0] XM_B,
    output logic        wb_we_out,
    output logic [4:0]  wb_reg_addr_out,
    output logic        stall_out,
    output logic        md_busy
);

    logic [31:0] op2, alu_res, md_hi, md_lo, xm_o_d;
    logic [4:0]  shamt;
    logic        wb_we_d;
    logic [31:0] xm_ir_q, xm_o_q, xm_b_q;
    logic        wb_we_q;
    logic [4:0]  wb_addr_q;

    assign op2   = use_imm ? DX_IMM : DX_B;
    assign shamt = DX_IR[10:6];

    always_comb begin
        alu_res = 32'h0;
        case (alu_op)
            AluAdd:  alu_res = DX_A + op2;
            AluSub:  alu_res = DX_A - op2;
            AluAnd:  alu_res = DX_A & op2;
            AluOr:   alu_res = DX_A | op2;
            AluXor:  alu_res = DX_A ^ op2;
            AluNor:  alu_res = ~(DX_A | op2);
            AluSlt:  alu_res = {31'h0, $signed(DX_A) < $signed(op2)};
            AluSltu: alu_res = {31'h0, DX_A < op2};
            AluSll:  alu_res = op2 << shamt;
            AluSrl:  alu_res = op2 >> shamt;
            AluSra:  alu_res = $signed(op2) >>> shamt;
            AluLui:  alu_res = {DX_IMM[15:0], 16'h0};
            default: alu_res = 32'h0;
        endcase
    end

`ifdef MULDIV_EN
    muldiv_iter u_muldiv (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (md_start),
        .hold_i  (stall_in),
        .op_i    (md_op),
        .a_i     (DX_A),
        .b_i     (DX_B),
        .busy_o  (md_busy),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    // Only instructions that touch HI/LO or the unit itself wait for it.
    assign stall_out = md_busy && ((mf_sel == MfHi) || (mf_sel == MfLo) || md_start);
    assign wb_we_d   = wb_we_in & ~md_start;
`else
    logic unused_md;
    assign unused_md = ^{md_start, md_op};
    assign md_busy   = 1'b0;
    assign md_hi     = 32'h0;
    assign md_lo     = 32'h0;
    assign stall_out = 1'b0;
    assign wb_we_d   = wb_we_in;
`endif

    always_comb begin
        xm_o_d = alu_res;
        case (mf_sel)
            MfHi:    xm_o_d = md_hi;
            MfLo:    xm_o_d = md_lo;
            default: xm_o_d = alu_res;
        endcase
    end

    // stall_in has priority over the interlock: hold rather than bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            xm_ir_q   <= NOP_IR;
            xm_o_q    <= '0;
            xm_b_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
        end else if (!stall_in) begin
            if (stall_out) begin
                xm_ir_q   <= NOP_IR;
                xm_o_q    <= '0;
                xm_b_q    <= '0;
                wb_we_q   <= 1'b0;
                wb_addr_q <= '0;
            end else begin
                xm_ir_q   <= DX_IR;
                xm_o_q    <= xm_o_d;
                xm_b_q    <= DX_B;
                wb_we_q   <= wb_we_d;
                wb_addr_q <= wb_reg_addr_in;
            end
        end
    end

    assign XM_IR           = xm_ir_q;
    assign XM_O            = xm_o_q;
    assign XM_B            = xm_b_q;
    assign wb_we_out       = wb_we_q;
    assign wb_reg_addr_out = wb_addr_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: driver pushes expected XM contents computed from an
// arithmetic reference model; a monitor pops and compares on every unstalled edge.
module tb_execute_pipe;
    import execute_pipe_pkg::*;

`ifdef MULDIV_EN
    localparam bit HasMd = 1'b1;
`else
    localparam bit HasMd = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic [31:0] DX_IR = '0, DX_A = '0, DX_B = '0, DX_IMM = '0;
    logic [3:0]  alu_op = '0;
    logic        use_imm = 1'b0, md_start = 1'b0, wb_we_in = 1'b0;
    logic [1:0]  md_op = '0, mf_sel = '0;
    logic [4:0]  wb_reg_addr_in = '0;
    logic [31:0] XM_IR, XM_O, XM_B;
    logic        wb_we_out, stall_out, md_busy;
    logic [4:0]  wb_reg_addr_out;

    execute_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .DX_IR           (DX_IR),
        .DX_A            (DX_A),
        .DX_B            (DX_B),
        .DX_IMM          (DX_IMM),
        .alu_op          (alu_op),
        .use_imm         (use_imm),
        .md_start        (md_start),
        .md_op           (md_op),
        .mf_sel          (mf_sel),
        .wb_we_in        (wb_we_in),
        .wb_reg_addr_in  (wb_reg_addr_in),
        .XM_IR           (XM_IR),
        .XM_O            (XM_O),
        .XM_B            (XM_B),
        .wb_we_out       (wb_we_out),
        .wb_reg_addr_out (wb_reg_addr_out),
        .stall_out       (stall_out),
        .md_busy         (md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir, a, b, imm;
        logic [3:0]  op;
        logic        ui, md, we;
        logic [1:0]  mdop, mf;
        logic [4:0]  addr;
    } instr_t;

    typedef struct {
        logic [31:0] ir, o, b;
        logic        we;
        logic [4:0]  addr;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input instr_t t);
        logic [31:0] y;
        logic [31:0] r;
        int sh;
        y  = t.ui ? t.imm : t.b;
        sh = int'(t.ir[10:6]);
        case (t.op)
            AluAdd:  r = t.a + y;
            AluSub:  r = t.a - y;
            AluAnd:  r = t.a & y;
            AluOr:   r = t.a | y;
            AluXor:  r = t.a ^ y;
            AluNor:  r = ~(t.a | y);
            AluSlt:  r = ($signed(t.a) < $signed(y)) ? 32'd1 : 32'd0;
            AluSltu: r = (t.a < y) ? 32'd1 : 32'd0;
            AluSll:  r = y << sh;
            AluSrl:  r = y >> sh;
            AluSra:  r = $signed(y) >>> sh;
            AluLui:  r = t.imm * 32'h0001_0000;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic md_ref(input instr_t t);
        longint sa, sbv, q, rm;
        logic [63:0] p;
        sa  = longint'($signed(t.a));
        sbv = longint'($signed(t.b));
        case (t.mdop)
            MdMult:  begin p = sa * sbv; hi_m = p[63:32]; lo_m = p[31:0]; end
            MdMultu: begin p = {32'h0, t.a} * {32'h0, t.b}; hi_m = p[63:32]; lo_m = p[31:0]; end
            default: begin
                if (t.b == 32'h0) begin
                    lo_m = 32'hFFFF_FFFF;
                    hi_m = t.a;
                end else if (t.mdop == MdDiv) begin
                    q = sa / sbv;
                    rm = sa % sbv;
                    lo_m = q[31:0];
                    hi_m = rm[31:0];
                end else begin
                    lo_m = t.a / t.b;
                    hi_m = t.a % t.b;
                end
            end
        endcase
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic ui, input logic md,
                                  input logic [1:0] mdop, input logic [1:0] mf);
        instr_t t;
        t.ir   = $urandom | 32'h0400_0000;
        t.a    = a;
        t.b    = b;
        t.imm  = imm;
        t.op   = op;
        t.ui   = ui;
        t.md   = md;
        t.mdop = mdop;
        t.mf   = mf;
        t.we   = 1'b1;
        t.addr = 5'($urandom_range(1, 31));
        return t;
    endfunction

    // Present t in DX until it is accepted; nso counts interlock-stalled edges.
    task automatic issue(input instr_t t, input int nstall, input bit rnd, output int nso);
        bit   done, si, so;
        exp_t e;
        done = 1'b0;
        nso  = 0;
        #1;
        DX_IR = t.ir; DX_A = t.a; DX_B = t.b; DX_IMM = t.imm;
        alu_op = t.op; use_imm = t.ui; md_start = t.md; md_op = t.mdop; mf_sel = t.mf;
        wb_we_in = t.we; wb_reg_addr_in = t.addr;
        for (int k = 0; k < 200 && !done; k++) begin
            stall_in = (k < nstall) ? 1'b1 : (rnd && $urandom_range(0, 7) == 0);
            @(negedge clk);
            si = stall_in;
            so = stall_out;
            @(posedge clk);
            if (!si && !so) begin
                e.ir   = t.ir;
                e.b    = t.b;
                e.addr = t.addr;
                e.we   = t.we && !(HasMd && t.md);
                e.o    = (t.mf == MfHi) ? hi_m : (t.mf == MfLo) ? lo_m : alu_ref(t);
                sb.push_back(e);
                if (HasMd && t.md) md_ref(t);
                done = 1'b1;
            end else begin
                if (so && !si) nso++;
                #1;
            end
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int n);
        #1;
        rst = 1'b1;
        stall_in = 1'b0;
        md_start = 1'b0;
        mf_sel = MfAlu;
        repeat (n) begin
            @(negedge clk);
            @(posedge clk);
        end
        hi_m = '0;
        lo_m = '0;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: decide what XM must hold after each edge from the pre-edge controls.
    initial begin
        bit   p_rst, p_si, p_so;
        exp_t last, bub, e;
        bub.ir = NOP_IR; bub.o = '0; bub.b = '0; bub.we = 1'b0; bub.addr = '0;
        last = bub;
        forever begin
            @(negedge clk);
            p_rst = rst;
            p_si  = stall_in;
            p_so  = stall_out;
            @(posedge clk);
            #1;
            if (p_rst) begin
                e = bub;
                chk("rst_busy", {31'h0, md_busy}, 32'h0);
            end else if (p_si) begin
                e = last;
            end else if (p_so) begin
                e = bub;
            end else if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
                e = last;
            end else begin
                e = sb.pop_front();
            end
            chk("xm_ir", XM_IR, e.ir);
            chk("xm_o", XM_O, e.o);
            chk("xm_b", XM_B, e.b);
            chk("wb_we", {31'h0, wb_we_out}, {31'h0, e.we});
            chk("wb_addr", {27'h0, wb_reg_addr_out}, {27'h0, e.addr});
            last = e;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int     nso;
        instr_t t;
        do_reset(2);

        issue(mk(AluAdd, 32'd7, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 0, 0, nso);
        issue(mk(AluSlt, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 0, 0, nso);
        issue(mk(AluSltu, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 0, 0, nso);
        issue(mk(AluLui, 32'h0, 32'h0, 32'h0000_1234, 1'b1, 1'b0, MdMult, MfAlu), 0, 0, nso);
        issue(mk(AluSra, 32'h0, 32'h8000_00F0, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 0, 0, nso);

        issue(mk(AluAdd, 32'hFFFF_FFFD, 32'd5, 32'h0, 1'b0, 1'b1, MdMult, MfAlu), 0, 0, nso);
        issue(mk(AluAdd, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, MdMult, MfLo), 0, 0, nso);
        chk("mflo_interlock_cycles", nso, HasMd ? 32'd33 : 32'd0);
        issue(mk(AluAdd, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, MdMult, MfHi), 0, 0, nso);
        chk("mfhi_no_stall", nso, 32'd0);

        issue(mk(AluAdd, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 1'b1, MdDiv, MfAlu), 0, 0, nso);
        issue(mk(AluOr, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 0, 0, nso);
        issue(mk(AluAdd, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, MdMult, MfLo), 0, 0, nso);
        issue(mk(AluAdd, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, MdMult, MfHi), 0, 0, nso);
        issue(mk(AluAdd, 32'd7, 32'd0, 32'h0, 1'b0, 1'b1, MdDivu, MfAlu), 0, 0, nso);
        issue(mk(AluAdd, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, MdMult, MfLo), 0, 0, nso);
        issue(mk(AluAdd, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, MdMult, MfHi), 0, 0, nso);

        // Three-cycle downstream stall in the middle of an ALU stream.
        issue(mk(AluXor, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 0, 0, nso);
        issue(mk(AluSub, 32'd3, 32'd10, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 3, 0, nso);
        issue(mk(AluNor, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 0, 0, nso);

        // Reset while the unit is at iteration 10.
        issue(mk(AluAdd, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1, MdMultu, MfAlu), 0, 0, nso);
        repeat (9) issue(mk(AluAnd, $urandom, $urandom, 32'h0, 1'b0, 1'b0, MdMult, MfAlu), 0, 0, nso);
        #1;
        chk("busy_mid_run", {31'h0, md_busy}, {31'h0, HasMd});
        do_reset(1);
        issue(mk(AluAdd, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, MdMult, MfHi), 0, 0, nso);
        chk("post_rst_no_stall", nso, 32'd0);
        issue(mk(AluAdd, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, MdMult, MfLo), 0, 0, nso);

        for (int i = 0; i < 300; i++) begin
            int sel;
            logic [31:0] imm16;
            sel   = $urandom_range(0, 9);
            imm16 = 32'($signed($urandom_range(0, 65535) - 32768));
            t = mk(4'($urandom_range(0, 11)), $urandom, $urandom, imm16, 1'($urandom_range(0, 1)),
                   1'b0, 2'($urandom_range(0, 3)), MfAlu);
            if ($urandom_range(0, 3) == 0) t.a = 32'($signed($urandom_range(0, 20) - 10));
            if (sel == 0) begin
                t.md = 1'b1;
                if ($urandom_range(0, 5) == 0) t.b = 32'h0;
            end else if (sel == 1) begin
                t.mf = MfHi;
            end else if (sel == 2) begin
                t.mf = MfLo;
            end
            issue(t, 0, 1, nso);
        end

        #2;
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Execute stage of the 5-stage MIPS pipeline: consumes DX pipeline registers from decode, computes ALU results, and drives the XM registers (`XM_IR`, `XM_O`, `XM_B`) and writeback control consumed directly by `mem_pipe`. It also contains an iterative multiply/divide unit with HI/LO registers that stalls the front end while busy.

## Interface

- `NOP_IR`, 32'h0000_0000, instruction word injected into `XM_IR` for bubbles and reset
- `MD_ITER`, 32, iterations per multiply/divide; fixed at 32, not for override
- `clk`  in  1  CPU clock
- `rst`  in  1  reset, synchronous and active-high
- `stall_in`  in  1  downstream stall; hold all XM outputs
- `DX_IR`, `DX_A`, `DX_B`, `DX_IMM`  in  32 each  instruction, rs value, rt value, sign-extended immediate
- `alu_op`  in  4  ALU function (const.v encodings)
- `use_imm`  in  1  operand 2 = `DX_IMM` instead of `DX_B`
- `md_start`  in  1  instruction is MULT/MULTU/DIV/DIVU
- `md_op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `mf_sel`  in  2  00 ALU, 01 MFHI, 10 MFLO
- `wb_we_in`  in  1, `wb_reg_addr_in`  in  5  writeback control from decode
- `XM_IR`, `XM_O`, `XM_B`  out  32 each  to memory stage
- `wb_we_out`  out  1, `wb_reg_addr_out`  out  5  registered writeback control
- `stall_out`  out  1  combinational; freeze fetch/decode
- `md_busy`  out  1  registered; FSM not IDLE

## Operation

- ALU ops: ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL, SRA (shift amount `DX_IR[10:6]`), LUI (imm<<16). Add/sub wrap mod 2^32; no overflow trap.
- `XM_O` = ALU result, or HI/LO per `mf_sel`. `XM_B` = `DX_B` (store data). Other XM fields pass through.
- MD FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when `md_start` and not `stall_in`; latch operands, load counter 0.
  - RUN: one shift-add (mult) or restoring subtract (div) step per cycle; -> DONE after 32 steps.
  - DONE: write HI/LO, -> IDLE.
- Signed ops: operate on magnitudes, correct signs at DONE; remainder takes dividend sign.
- Divide by zero: LO = 32'hFFFF_FFFF, HI = dividend; no exception.
- MD instruction itself enters XM as a bubble-free slot with `wb_we_out` = 0.
- MFHI/MFLO in DX while FSM not IDLE: interlock; `stall_out` = 1 until IDLE.

## Timing

- Reset: `XM_IR` = `NOP_IR`, `XM_O` = `XM_B` = 0, `wb_we_out` = 0, `wb_reg_addr_out` = 0, HI = LO = 0, FSM IDLE, `md_busy` = 0. Reset mid-RUN aborts; HI/LO cleared.
- ALU latency 1 cycle: DX at edge N appears on XM after edge N.
- MD: start edge N, HI/LO valid after edge N+33; `stall_out` high edges N+1..N+33 only if next DX instruction is MFHI/MFLO or another `md_start`; independent instructions proceed.
- While `stall_out` = 1 and `stall_in` = 0, XM takes a bubble (`NOP_IR`, `wb_we_out` = 0).
- `stall_in` = 1: XM, HI/LO write, and FSM start held; RUN iterations continue.
- `stall_in` and interlock simultaneous: `stall_in` wins; XM held, no bubble.

## Configuration

- `MULDIV_EN` defined: MD unit, HI/LO, interlock compiled in.
- Undefined: `md_start` ignored, MFHI/MFLO return 0, `md_busy` tied 0, `stall_out` = 0.

## Structure

- const.v gains ALU op codes, `md_op` codes, `NOP_IR` value, and `MD_ITER`.
- One sub-module `muldiv_iter`: FSM, counter, operand/partial registers, HI/LO; interface start/op/a/b/busy/hi/lo.

## Test plan

- ADD 7 + 32'hFFFF_FFFF -> `XM_O` = 6 one cycle later; SLT -1 < 1 -> 1, SLTU -> 0.
- MULT -3 × 5 then MFLO -> `stall_out` until done, XM_O = 32'hFFFF_FFF1, MFHI = 32'hFFFF_FFFF.
- DIV -7 / 2 -> LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF; DIVU 7 / 0 -> LO = 32'hFFFF_FFFF, HI = 7.
- `stall_in` asserted 3 cycles mid-stream -> XM outputs constant; no bubble, no loss.
- `rst` at RUN step 10 -> next cycle `md_busy` = 0, HI = LO = 0, `XM_IR` = `NOP_IR`.
